i2c_cmd_sequencer: RTL and testbench

Command-queue front end that sits directly upstream of the I2C master controller and feeds it. Accepts I2C transactions (address, R/W, write byte) from a host on a valid/ready stream and buffers them in a FIFO. Issues them one at a time over the master's enable/ready handshake, then returns one response per command (read byte, R/W echo, error flag) on a second valid/ready stream.

---
 rtl/i2c_cmd_sequencer_if.sv | 19 +
 rtl/i2c_cmd_sequencer.sv | 96 +++++++++
 tb/tb_i2c_cmd_sequencer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/i2c_cmd_sequencer_if.sv
// i2c_cmd_sequencer_if: host command/response streams and I2C master handshake
interface i2c_cmd_sequencer_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8
);
  logic                  cmd_valid, cmd_ready, cmd_rw;
  logic [ADDR_WIDTH-1:0] cmd_addr, m_address;
  logic [DATA_WIDTH-1:0] cmd_data, rsp_data, m_data_in, m_data_out;
  logic                  rsp_valid, rsp_ready, rsp_rw, rsp_err;
  logic                  m_rw, m_enable, m_ready;
  modport slave (
    input  cmd_valid, cmd_addr, cmd_rw, cmd_data, rsp_ready, m_data_out, m_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_rw, rsp_err, m_address, m_data_in, m_rw, m_enable
  );
  modport master (
    output cmd_valid, cmd_addr, cmd_rw, cmd_data, rsp_ready, m_data_out, m_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_rw, rsp_err, m_address, m_data_in, m_rw, m_enable
  );
endinterface

// File: rtl/i2c_cmd_sequencer.sv
// i2c_cmd_sequencer: FIFO-buffered command front end for an I2C master; I2C_SEQ_TIMEOUT_EN adds per-phase timeout
module i2c_cmd_sequencer #(
  parameter int ADDR_WIDTH     = 7,
  parameter int DATA_WIDTH     = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                             clk,
  input  logic                             rst,
  i2c_cmd_sequencer_if.slave               bus,
  output logic                             busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  cmd_count
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = 1 + ADDR_WIDTH + DATA_WIDTH;
  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, RESP} state_t;
  state_t                state, nxt;
  logic [EW-1:0]         mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic                  push, pop, load, tmo, err_q;
  logic [ADDR_WIDTH-1:0] m_addr_q;
  logic [DATA_WIDTH-1:0] m_data_q, rsp_data_q;
  logic                  m_rw_q, rsp_valid_q, rsp_rw_q, rsp_err_q;
  assign bus.cmd_ready = cmd_count != CW'(FIFO_DEPTH);
  assign push          = bus.cmd_valid && bus.cmd_ready;
  assign busy          = (cmd_count != '0) || (state != IDLE);
  // gating with m_ready drops enable in the very cycle the master leaves IDLE
  assign bus.m_enable  = (state == LAUNCH) && bus.m_ready;
  assign bus.m_address = m_addr_q;
  assign bus.m_data_in = m_data_q;
  assign bus.m_rw      = m_rw_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_rw    = rsp_rw_q;
  assign bus.rsp_err   = rsp_err_q;
  always_comb begin
    nxt  = state;
    pop  = 1'b0;
    load = 1'b0;
    case (state)
      IDLE: if (cmd_count != '0 && bus.m_ready && !rsp_valid_q) begin
        nxt  = LAUNCH;
        load = 1'b1;
      end
      LAUNCH: if (!bus.m_ready || tmo) begin
        pop = 1'b1;
        nxt = bus.m_ready ? RESP : RUN;
      end
      RUN: nxt = (bus.m_ready || tmo) ? RESP : RUN;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {bus.cmd_rw, bus.cmd_addr, bus.cmd_data};
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cmd_count   <= '0;
      m_addr_q    <= '0;
      m_data_q    <= '0;
      m_rw_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_rw_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state     <= nxt;
      wr_ptr    <= wr_ptr + PW'(push);
      rd_ptr    <= rd_ptr + PW'(pop);
      cmd_count <= cmd_count + CW'(push) - CW'(pop);
      if (load) {m_rw_q, m_addr_q, m_data_q} <= mem[rd_ptr];
      if (state == RESP) begin
        rsp_valid_q <= 1'b1;
        rsp_rw_q    <= m_rw_q;
        rsp_data_q  <= (m_rw_q && !err_q) ? bus.m_data_out : '0;
        rsp_err_q   <= err_q;
      end else if (rsp_valid_q && bus.rsp_ready) rsp_valid_q <= 1'b0;
    end
  end
`ifdef I2C_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
  assign tmo = tcnt == TW'(TIMEOUT_CYCLES - 1);
  // any state change clears the count, so LAUNCH and RUN each start from zero
  always_ff @(posedge clk) begin
    tcnt  <= (rst || state != nxt) ? '0 : tcnt + 1'b1;
    err_q <= (rst || load) ? 1'b0 : err_q | (nxt == RESP && (state == LAUNCH || !bus.m_ready));
  end
`else
  assign tmo   = 1'b0;
  assign err_q = 1'b0;
`endif
endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// tb_i2c_cmd_sequencer: directed bench with a simple I2C master model and response checks
module tb_i2c_cmd_sequencer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       busy;
  logic [2:0] cmd_count;
  always #5 clk = ~clk;
  i2c_cmd_sequencer_if #(.ADDR_WIDTH(7), .DATA_WIDTH(8)) bus();
  i2c_cmd_sequencer #(.ADDR_WIDTH(7), .DATA_WIDTH(8), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .cmd_count(cmd_count)
  );
  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // master model: read data is {0,addr}^0x66, writes return 0
  logic       rdy, cur_rw;
  logic [6:0] cur_addr;
  bit         hold = 0, ignore = 0;
  int         busy_cyc = 6, bcnt = 0, en_edges = 0;
  logic [6:0] log_addr[$];
  logic       log_rw[$];
  logic [7:0] log_data[$];
  assign bus.m_ready = hold ? 1'b0 : rdy;
  always @(posedge clk) begin
    if (bus.m_enable) en_edges++;
    if (rst) begin
      rdy            <= 1'b1;
      bus.m_data_out <= 8'h00;
      bcnt           <= 0;
    end else if (rdy) begin
      if (bus.m_enable && !ignore && !hold) begin
        rdy      <= 1'b0;
        bcnt     <= busy_cyc;
        cur_rw   <= bus.m_rw;
        cur_addr <= bus.m_address;
        log_addr.push_back(bus.m_address);
        log_rw.push_back(bus.m_rw);
        log_data.push_back(bus.m_data_in);
      end
    end else if (bcnt == 0) begin
      rdy            <= 1'b1;
      bus.m_data_out <= cur_rw ? ({1'b0, cur_addr} ^ 8'h66) : 8'h00;
    end else bcnt <= bcnt - 1;
  end
  task automatic push(input logic [6:0] a, input logic rw, input logic [7:0] d);
    int i;
    bus.cmd_addr  = a;
    bus.cmd_rw    = rw;
    bus.cmd_data  = d;
    bus.cmd_valid = 1'b1;
    for (i = 0; i < 500 && !bus.cmd_ready; i++) @(negedge clk);
    chk("push_ready", bus.cmd_ready, 1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask
  task automatic get_rsp(input string tag, input logic [7:0] d, input logic rw, input logic err);
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 1000 && !bus.rsp_valid; i++) @(negedge clk);
    chk({tag, "_valid"}, bus.rsp_valid, 1);
    chk({tag, "_data"}, bus.rsp_data, d);
    chk({tag, "_rw"}, bus.rsp_rw, rw);
    chk({tag, "_err"}, bus.rsp_err, err);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask
  task automatic chk_log(input int idx, input logic [6:0] a, input logic rw, input logic [7:0] d);
    chk("log_size", log_addr.size() > idx, 1);
    if (log_addr.size() > idx) begin
      chk("log_addr", log_addr[idx], a);
      chk("log_rw", log_rw[idx], rw);
      chk("log_data", log_data[idx], d);
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int e0, n;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_rw    = 1'b0;
    bus.cmd_data  = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_rsp_rw", bus.rsp_rw, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_m_enable", bus.m_enable, 0);
    chk("rst_m_address", bus.m_address, 0);
    chk("rst_m_data_in", bus.m_data_in, 0);
    chk("rst_m_rw", bus.m_rw, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", cmd_count, 0);
    rst = 1'b0;
    @(negedge clk);
    // single write into an idle sequencer
    e0 = en_edges;
    push(7'h50, 1'b0, 8'hA5);
    chk("wr_count", cmd_count, 1);
    chk("wr_en_early", bus.m_enable, 0);
    @(negedge clk);
    chk("wr_en", bus.m_enable, 1);
    chk("wr_addr", bus.m_address, 7'h50);
    chk("wr_rw", bus.m_rw, 0);
    chk("wr_din", bus.m_data_in, 8'hA5);
    get_rsp("wr", 8'h00, 1'b0, 1'b0);
    chk("wr_pulses", en_edges - e0, 1);
    chk("wr_addr_held", bus.m_address, 7'h50);
    chk_log(0, 7'h50, 1'b0, 8'hA5);
    // single read; enable must fall with m_ready
    e0 = en_edges;
    push(7'h3C, 1'b1, 8'h00);
    for (int i = 0; i < 50 && bus.m_ready; i++) @(negedge clk);
    chk("rd_ready_fell", bus.m_ready, 0);
    chk("rd_en_drop", bus.m_enable, 0);
    get_rsp("rd", 8'h5A, 1'b1, 1'b0);
    chk("rd_pulses", en_edges - e0, 1);
    chk_log(1, 7'h3C, 1'b1, 8'h00);
    // five commands against a busy master
    hold = 1;
    push(7'h11, 1'b0, 8'h01);
    push(7'h22, 1'b1, 8'h02);
    push(7'h33, 1'b0, 8'h03);
    push(7'h44, 1'b1, 8'h04);
    chk("full_count", cmd_count, 4);
    chk("full_ready", bus.cmd_ready, 0);
    chk("full_busy", busy, 1);
    fork
      push(7'h55, 1'b1, 8'h05);
      begin
        repeat (5) @(negedge clk);
        chk("full_hold", bus.cmd_ready, 0);
        hold = 0;
      end
    join
    get_rsp("q1", 8'h00, 1'b0, 1'b0);
    get_rsp("q2", 8'h44, 1'b1, 1'b0);
    get_rsp("q3", 8'h00, 1'b0, 1'b0);
    get_rsp("q4", 8'h22, 1'b1, 1'b0);
    get_rsp("q5", 8'h33, 1'b1, 1'b0);
    chk_log(2, 7'h11, 1'b0, 8'h01);
    chk_log(3, 7'h22, 1'b1, 8'h02);
    chk_log(4, 7'h33, 1'b0, 8'h03);
    chk_log(5, 7'h44, 1'b1, 8'h04);
    chk_log(6, 7'h55, 1'b1, 8'h05);
    // unconsumed response blocks further launches
    push(7'h3C, 1'b1, 8'h00);
    push(7'h12, 1'b0, 8'h34);
    push(7'h13, 1'b0, 8'h56);
    for (int i = 0; i < 200 && !bus.rsp_valid; i++) @(negedge clk);
    e0 = en_edges;
    repeat (20) @(negedge clk);
    chk("stall_no_en", en_edges - e0, 0);
    chk("stall_valid", bus.rsp_valid, 1);
    chk("stall_data", bus.rsp_data, 8'h5A);
    chk("stall_count", cmd_count, 2);
    get_rsp("s1", 8'h5A, 1'b1, 1'b0);
    get_rsp("s2", 8'h00, 1'b0, 1'b0);
    get_rsp("s3", 8'h00, 1'b0, 1'b0);
    chk_log(8, 7'h12, 1'b0, 8'h34);
    // reset while a transaction runs with three queued
    busy_cyc = 40;
    push(7'h21, 1'b0, 8'h01);
    push(7'h22, 1'b0, 8'h02);
    push(7'h23, 1'b0, 8'h03);
    push(7'h24, 1'b0, 8'h04);
    for (int i = 0; i < 50 && !(cmd_count == 3 && !bus.m_ready); i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("run_count", cmd_count, 3);
    chk("run_en", bus.m_enable, 0);
    chk("run_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_count", cmd_count, 0);
    chk("mrst_en", bus.m_enable, 0);
    chk("mrst_valid", bus.rsp_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_ready", bus.cmd_ready, 1);
    rst = 1'b0;
    busy_cyc = 6;
    @(negedge clk);
    push(7'h3C, 1'b1, 8'h00);
    get_rsp("post", 8'h5A, 1'b1, 1'b0);
`ifdef I2C_SEQ_TIMEOUT_EN
    // master never leaves IDLE: LAUNCH times out after 16 cycles
    ignore = 1;
    push(7'h3C, 1'b1, 8'h00);
    for (int i = 0; i < 50 && !bus.m_enable; i++) @(negedge clk);
    n = 0;
    while (!bus.rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_latency", n, 17);
    chk("tmo_count", cmd_count, 0);
    chk("tmo_en", bus.m_enable, 0);
    get_rsp("tmo", 8'h00, 1'b1, 1'b1);
    ignore = 0;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
